// File: rtl/seq_chunk_adder.sv
// Multi-cycle ripple-carry adder/subtractor: adds CHUNK bits per clock and keeps the
// carry in a register between chunks, so WIDTH-bit operands take WIDTH/CHUNK cycles.
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Handshake: start/sub/A/B/Cin are sampled on a rising edge only while busy is low
  // (IDLE or DONE); done is a single-cycle pulse and S/Cout/ovf hold until the next
  // accepted start or reset.
  state_t           state_q;
  logic [WIDTH-1:0] opa_q, opb_q, s_q;
  logic             carry_q, cout_q, ovf_q, busy_q, done_q;
  logic [IW-1:0]    idx_q;

  logic [CHUNK-1:0] a_chunk_d, b_chunk_d, sum_chunk_d;
  logic             carry_d, msb_cin_d, last_d;
  int               base_d;

  always_comb begin
    base_d    = int'(idx_q) * CHUNK;
    a_chunk_d = opa_q[base_d +: CHUNK];
    b_chunk_d = opb_q[base_d +: CHUNK];
    {carry_d, sum_chunk_d} = {1'b0, a_chunk_d} + {1'b0, b_chunk_d} + {{CHUNK{1'b0}}, carry_q};
    // Carry into the top bit recovered from that bit's own sum: s = a ^ b ^ cin.
    msb_cin_d = a_chunk_d[CHUNK-1] ^ b_chunk_d[CHUNK-1] ^ sum_chunk_d[CHUNK-1];
    last_d    = (idx_q == IW'(NCHUNK - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            // Subtraction is A + ~B + ~Cin, i.e. A - B - Cin.
            opa_q   <= A;
            opb_q   <= sub ? ~B : B;
            carry_q <= sub ? ~Cin : Cin;
            idx_q   <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        RUN: begin
          s_q[base_d +: CHUNK] <= sum_chunk_d;
          carry_q              <= carry_d;
          idx_q                <= idx_q + IW'(1);
          if (last_d) begin
            cout_q  <= carry_d;
            ovf_q   <= msb_cin_d ^ carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign S         = s_q;
  assign Cout      = cout_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule
